cpu_axi_master: RTL and testbench
=================================

Name: cpu_axi_master

Overview:
- Single-outstanding AXI master that turns a simple CPU-side memory request into one single-beat AXI read or write transaction.
- It sits between a CPU fetch or data port and the AXI interconnect.
- It is the initiator counterpart of the team's SRAM slave wrappers: AW is issued strictly before W, and every transfer is a single beat.

Parameters:
- MASTER_ID, 4'd0, constant value driven on ARID and AWID.
- ADDR_W, 32, width of the CPU address and of ARADDR/AWADDR.

Ports:
- ACLK  input  1  clock; all logic is rising-edge.
- ARESETn  input  1  asynchronous active-low reset.
- mem_req  input  1  CPU request strobe; sampled only in IDLE.
- mem_web  input  4  active-low byte write enables; 4'b1111 means read.
- mem_addr  input  32  byte address.
- mem_wdata  input  32  write data.
- mem_rdata  output  32  registered read data.
- mem_done  output  1  one-cycle completion pulse.
- mem_err  output  1  pulses with mem_done when the response is not OKAY.
- mem_stall  output  1  the CPU must hold its pipeline while this is high.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  output  4/32/4/3/2  write-address payload.
- AWVALID  output  1 / AWREADY  input  1  write-address handshake.
- WDATA/WSTRB/WLAST  output  32/4/1  write-data payload.
- WVALID  output  1 / WREADY  input  1  write-data handshake.
- BID/BRESP  input  8/2  write response (BID is ignored).
- BVALID  input  1 / BREADY  output  1  write-response handshake.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  output  4/32/4/3/2  read-address payload.
- ARVALID  output  1 / ARREADY  input  1  read-address handshake.
- RID/RDATA/RRESP/RLAST  input  8/32/2/1  read-data payload (RID is ignored).
- RVALID  input  1 / RREADY  output  1  read-data handshake.

Behaviour:
- States: IDLE, AR, R, AW, W, B. The state register is asynchronously reset to IDLE.
- IDLE:
  - On mem_req, latch addr, wdata and web into buffers.
  - Next state is AR if web==4'b1111, otherwise AW.
  - Requests arriving while not in IDLE are ignored; the CPU holds mem_req because mem_stall is high.
- AR:
  - ARVALID=1 and ARADDR=addr_buf.
  - Stay until ARVALID&ARREADY, then go to R.
  - ARVALID and the payload stay stable until the handshake.
- R:
  - RREADY=1.
  - On RVALID: mem_rdata<=RDATA, mem_done<=1, mem_err<=(RRESP!=2'b00), then go to IDLE.
  - RLAST is not checked; a single beat is assumed.
- AW:
  - AWVALID=1 and AWADDR=addr_buf.
  - On AWREADY go to W.
  - WVALID stays 0 in this state; write data is never presented before the address.
- W:
  - WVALID=1, WDATA=wdata_buf, WSTRB=web_buf, WLAST=1.
  - WSTRB carries the active-low byte enables unchanged, matching the slave wrappers' WEB usage.
  - On WREADY go to B.
- B:
  - BREADY=1.
  - On BVALID: mem_done<=1, mem_err<=(BRESP!=2'b00), then go to IDLE.
- Constant payload fields: AxLEN=4'd0, AxSIZE=3'b010, AxBURST=2'b01, AxID=MASTER_ID.
- VALID and READY outputs are combinational decodes of the current state only.
- mem_done and mem_err:
  - Both are registered.
  - Each is high for exactly one cycle, the cycle after the final handshake, with the state already back in IDLE.
- mem_stall = (state!=IDLE) | (state==IDLE & mem_req & ~mem_done).
  - In the mem_done cycle the stall drops, so the CPU advances.
  - A new mem_req presented in the cycle after mem_done is accepted normally.
- mem_rdata holds its last value until the next read completes; writes do not change it.
- Minimum latency with a zero-wait slave:
  - Read: 3 cycles from req to mem_done.
  - Write: 4 cycles from req to mem_done.
- Reset values:
  - All VALID/READY outputs, mem_done and mem_err are 0.
  - mem_rdata and all buffers are 0; web_buf resets to 4'b1111.
  - WLAST is 0.
- Reset asserted mid-transaction aborts the transfer immediately; no VALID stays asserted and no mem_done is produced.
- If ARREADY/AWREADY/WREADY is held low indefinitely, the block waits indefinitely; there is no timeout.

Test Plan:
- Read, zero wait: req with web=4'b1111, addr=0x0000_0010 and a slave returning RDATA=0xDEAD_BEEF, RRESP=0 -> ARADDR=0x10 and ARLEN=0; mem_rdata=0xDEADBEEF, mem_done pulses 1 cycle, mem_err=0, 3 cycles total.
- Write: web=4'b1100, addr=0x20, wdata=0x1234_5678 -> AW handshake precedes WVALID; WSTRB=4'b1100, WLAST=1; mem_done one cycle after BVALID; mem_rdata unchanged.
- Backpressure: ARREADY delayed 5 cycles, then RVALID delayed 3 cycles -> ARVALID and ARADDR stay stable throughout; mem_stall stays high; exactly one mem_done.
- Error response: RRESP=2'b10 on a read, and BRESP=2'b11 on a write -> mem_err pulses with mem_done in each case.
- Back-to-back requests: a read followed by a write, with req held across the mem_done cycle -> the second transaction starts the cycle after mem_done; no request is dropped or duplicated.
- Reset mid-write: ARESETn low while in W -> WVALID drops asynchronously; after release all outputs are at reset values and the state is IDLE.

Source files
------------

// File: rtl/cpu_axi_master.sv
// rtl/cpu_axi_master.sv - single-outstanding CPU-to-AXI master issuing one single-beat read or write
module cpu_axi_master #(
    parameter logic [3:0] MASTER_ID = 4'd0,
    parameter int         ADDR_W    = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,

    input  logic              mem_req,
    input  logic [3:0]        mem_web,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              mem_err,
    output logic              mem_stall,

    output logic [3:0]        AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [3:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,

    output logic [31:0]       WDATA,
    output logic [3:0]        WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,

    input  logic [7:0]        BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,

    output logic [3:0]        ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,

    input  logic [7:0]        RID,
    input  logic [31:0]       RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_buf;
    logic [31:0]       wdata_buf;
    logic [3:0]        web_buf;
    logic              done_d;
    logic              err_d;
    logic              accept;
    logic              unused_inputs;

    // The request still held during the mem_done cycle belongs to the
    // transfer that just finished, so it must not be taken again.
    assign accept = (state == ST_IDLE) & mem_req & ~mem_done;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= ST_IDLE;
            addr_buf  <= '0;
            wdata_buf <= '0;
            web_buf   <= 4'b1111;
            mem_rdata <= '0;
            mem_done  <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            state    <= state_d;
            mem_done <= done_d;
            mem_err  <= err_d;
            if (accept) begin
                addr_buf  <= mem_addr;
                wdata_buf <= mem_wdata;
                web_buf   <= mem_web;
            end
            if (state == ST_R && RVALID) begin
                mem_rdata <= RDATA;
            end
        end
    end

    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (mem_web == 4'b1111) ? ST_AR : ST_AW;
                end
            end
            ST_AR: begin
                if (ARREADY) state_d = ST_R;
            end
            ST_R: begin
                if (RVALID) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = (RRESP != 2'b00);
                end
            end
            ST_AW: begin
                if (AWREADY) state_d = ST_W;
            end
            ST_W: begin
                if (WREADY) state_d = ST_B;
            end
            ST_B: begin
                if (BVALID) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = (BRESP != 2'b00);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_stall = (state != ST_IDLE) | (mem_req & ~mem_done);

    assign ARVALID = (state == ST_AR);
    assign RREADY  = (state == ST_R);
    assign AWVALID = (state == ST_AW);
    assign WVALID  = (state == ST_W);
    assign WLAST   = (state == ST_W);
    assign BREADY  = (state == ST_B);

    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_buf;
    assign ARLEN   = 4'd0;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;

    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_buf;
    assign AWLEN   = 4'd0;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;

    // Byte enables go out active-low, as the slave wrappers consume them.
    assign WDATA = wdata_buf;
    assign WSTRB = web_buf;

    assign unused_inputs = ^{BID, RID, RLAST};

endmodule

// File: tb/tb_cpu_axi_master.sv
// tb/tb_cpu_axi_master.sv - randomized bench for cpu_axi_master with a transaction-level model
module tb_cpu_axi_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        mem_req;
    logic [3:0]  mem_web;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_err;
    logic        mem_stall;
    logic [3:0]  AWID, AWLEN, ARID, ARLEN;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [3:0]  WSTRB;
    logic [7:0]  BID, RID;

    always #5 ACLK = ~ACLK;

    cpu_axi_master dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .mem_req(mem_req), .mem_web(mem_web), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err), .mem_stall(mem_stall),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int done_cnt = 0;

    // slave behaviour knobs
    int          ar_wait, aw_wait, w_wait, r_wait, b_wait, rdy_pct, vld_pct;
    bit          fix_en;
    logic [31:0] fix_rdata;
    logic [1:0]  fix_rresp, fix_bresp;

    // transaction-level model state
    logic        m_out = 1'b0, m_rd = 1'b0, m_was_rd = 1'b0;
    logic        m_ar_done = 1'b0, m_aw_done = 1'b0, m_w_done = 1'b0;
    logic        m_done_pend = 1'b0, m_err_pend = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0, m_rdata_pend = '0;
    logic [3:0]  m_web = 4'hF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit chance(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    function automatic logic [1:0] rand_resp();
        if ($urandom_range(0, 3) == 0) return 2'($urandom_range(1, 3));
        return 2'b00;
    endfunction

    task automatic slave_loop();
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend;
        int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
        r_pend = 0; b_pend = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        forever begin
            @(negedge ACLK);
            ar_hs = ARVALID && ARREADY;
            r_hs  = RVALID && RREADY;
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            b_hs  = BVALID && BREADY;
            if (ARVALID && !ARREADY) ar_cnt++;
            if (AWVALID && !AWREADY) aw_cnt++;
            if (WVALID && !WREADY) w_cnt++;
            if (r_pend && !RVALID) r_cnt++;
            if (b_pend && !BVALID) b_cnt++;
            if (ar_hs) ar_cnt = 0;
            if (aw_hs) aw_cnt = 0;
            if (w_hs) w_cnt = 0;
            @(posedge ACLK);
            #1;
            if (!ARESETn) begin
                r_pend = 0; b_pend = 0; RVALID = 0; BVALID = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
            end else begin
                if (r_hs) begin RVALID = 0; r_pend = 0; end
                if (b_hs) begin BVALID = 0; b_pend = 0; end
                if (ar_hs) begin r_pend = 1; r_cnt = 0; end
                if (w_hs) begin b_pend = 1; b_cnt = 0; end
                if (r_pend && !RVALID && r_cnt >= r_wait && chance(vld_pct)) begin
                    RVALID = 1;
                    RDATA  = fix_en ? fix_rdata : $urandom;
                    RRESP  = fix_en ? fix_rresp : rand_resp();
                    RID    = 8'($urandom);
                    RLAST  = 1;
                end
                if (b_pend && !BVALID && b_cnt >= b_wait && chance(vld_pct)) begin
                    BVALID = 1;
                    BRESP  = fix_en ? fix_bresp : rand_resp();
                    BID    = 8'($urandom);
                end
            end
            ARREADY = (ar_cnt >= ar_wait) && chance(rdy_pct);
            AWREADY = (aw_cnt >= aw_wait) && chance(rdy_pct);
            WREADY  = (w_cnt >= w_wait) && chance(rdy_pct);
        end
    endtask

    task automatic monitor_loop();
        logic       exp_done, exp_err, exp_stall;
        logic [4:0] ev;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                m_out = 0; m_done_pend = 0; m_rdata = '0;
            end
            exp_done = m_done_pend;
            exp_err  = m_done_pend & m_err_pend;
            if (m_done_pend && m_was_rd) m_rdata = m_rdata_pend;
            m_done_pend = 0;
            exp_stall = m_out | (mem_req & ~exp_done);
            chk("mem_done", 64'(mem_done), 64'(exp_done));
            chk("mem_err", 64'(mem_err), 64'(exp_err));
            chk("mem_rdata", 64'(mem_rdata), 64'(m_rdata));
            chk("mem_stall", 64'(mem_stall), 64'(exp_stall));
            if (mem_done) done_cnt++;
            ev = {m_out & m_rd & ~m_ar_done,
                  m_out & m_rd & m_ar_done,
                  m_out & ~m_rd & ~m_aw_done,
                  m_out & ~m_rd & m_aw_done & ~m_w_done,
                  m_out & ~m_rd & m_w_done};
            chk("valid_ready", 64'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 64'(ev));
            chk("axi_const", 64'({ARID, ARLEN, ARSIZE, ARBURST, AWID, AWLEN, AWSIZE, AWBURST}),
                64'({4'd0, 4'd0, 3'b010, 2'b01, 4'd0, 4'd0, 3'b010, 2'b01}));
            if (ev[4]) chk("araddr", 64'(ARADDR), 64'(m_addr));
            if (ev[2]) chk("awaddr", 64'(AWADDR), 64'(m_addr));
            if (ev[1]) begin
                chk("wdata", 64'(WDATA), 64'(m_wdata));
                chk("wstrb", 64'(WSTRB), 64'(m_web));
                chk("wlast", 64'(WLAST), 64'd1);
            end
            if (ARESETn) begin
                if (!m_out) begin
                    if (mem_req && !exp_done) begin
                        m_out = 1; m_rd = (mem_web == 4'hF);
                        m_addr = mem_addr; m_wdata = mem_wdata; m_web = mem_web;
                        m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
                    end
                end else if (m_rd) begin
                    if (!m_ar_done) begin
                        if (ARREADY) m_ar_done = 1;
                    end else if (RVALID) begin
                        m_out = 0; m_done_pend = 1; m_was_rd = 1;
                        m_err_pend = (RRESP != 2'b00); m_rdata_pend = RDATA;
                    end
                end else begin
                    if (!m_aw_done) begin
                        if (AWREADY) m_aw_done = 1;
                    end else if (!m_w_done) begin
                        if (WREADY) m_w_done = 1;
                    end else if (BVALID) begin
                        m_out = 0; m_done_pend = 1; m_was_rd = 0;
                        m_err_pend = (BRESP != 2'b00);
                    end
                end
            end
        end
    endtask

    task automatic do_req(input logic [3:0] web, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic err, output logic [31:0] rdata);
        bit got;
        got = 0; lat = 0; err = 0; rdata = '0;
        mem_req = 1; mem_web = web; mem_addr = addr; mem_wdata = wdata;
        for (int i = 0; i < 400; i++) begin
            @(negedge ACLK);
            if (mem_done) begin
                got = 1; err = mem_err; rdata = mem_rdata;
                break;
            end
            lat++;
        end
        chk("req_completes", 64'(got), 64'd1);
        req_cnt++;
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle(input int n);
        mem_req = 0;
        mem_addr = $urandom;
        mem_web = 4'($urandom);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic set_slave(input int arw, input int rw, input int rdy, input int vld);
        ar_wait = arw; aw_wait = 0; w_wait = 0; r_wait = rw; b_wait = 0;
        rdy_pct = rdy; vld_pct = vld;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, 64'({ARVALID, RREADY, AWVALID, WVALID, BREADY, WLAST, mem_done, mem_err}), 64'd0);
        chk({tag, "_rdata"}, 64'(mem_rdata), 64'd0);
    endtask

    initial begin
        int          lat, lat2;
        logic        err;
        logic [31:0] rd;
        logic [3:0]  web;
        bit          seen;

        ARESETn = 0; mem_req = 0; mem_web = 4'hF; mem_addr = '0; mem_wdata = '0;
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
        BID = '0; BRESP = '0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 0;
        set_slave(0, 0, 100, 100);
        fix_en = 1; fix_rdata = 32'hDEAD_BEEF; fix_rresp = 2'b00; fix_bresp = 2'b00;
        fork
            monitor_loop();
            slave_loop();
        join_none
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1;
        @(negedge ACLK);
        chk_reset_outputs("reset");
        @(posedge ACLK);
        #1;

        // zero-wait read and write
        do_req(4'hF, 32'h0000_0010, 32'h0, lat, err, rd);
        chk("rd_latency", 64'(lat), 64'd3);
        chk("rd_data", 64'(rd), 64'h0000_0000_DEAD_BEEF);
        chk("rd_err", 64'(err), 64'd0);
        idle(2);
        do_req(4'b1100, 32'h0000_0020, 32'h1234_5678, lat, err, rd);
        chk("wr_latency", 64'(lat), 64'd4);
        chk("wr_keeps_rdata", 64'(rd), 64'h0000_0000_DEAD_BEEF);
        chk("wr_err", 64'(err), 64'd0);
        idle(2);

        // backpressure on AR then R
        set_slave(5, 3, 100, 100);
        fix_rdata = 32'hCAFE_F00D;
        idle(2);
        do_req(4'hF, 32'h0000_0104, 32'h0, lat, err, rd);
        chk("bp_latency", 64'(lat), 64'd11);
        chk("bp_data", 64'(rd), 64'h0000_0000_CAFE_F00D);
        set_slave(0, 0, 100, 100);
        idle(2);

        // error responses
        fix_rresp = 2'b10; fix_rdata = 32'h0BAD_0BAD;
        do_req(4'hF, 32'h0000_0200, 32'h0, lat, err, rd);
        chk("rd_slverr", 64'(err), 64'd1);
        idle(1);
        fix_rresp = 2'b00; fix_bresp = 2'b11;
        do_req(4'b0000, 32'h0000_0204, 32'hA5A5_5A5A, lat, err, rd);
        chk("wr_decerr", 64'(err), 64'd1);
        fix_bresp = 2'b00;
        idle(1);

        // back-to-back read then write, request held across mem_done
        fix_rdata = 32'h1357_9BDF;
        do_req(4'hF, 32'h0000_0300, 32'h0, lat, err, rd);
        do_req(4'b0111, 32'h0000_0304, 32'h2468_ACE0, lat2, err, rd);
        chk("b2b_rd_latency", 64'(lat), 64'd3);
        chk("b2b_wr_latency", 64'(lat2), 64'd4);
        chk("b2b_rdata", 64'(rd), 64'h0000_0000_1357_9BDF);
        idle(2);

        // reset while the write data phase is stalled
        w_wait = 1000;
        idle(1);
        mem_req = 1; mem_web = 4'b0011; mem_addr = 32'h40; mem_wdata = 32'hFEED_FACE;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (WVALID) begin seen = 1; break; end
        end
        chk("rst_wvalid_seen", 64'(seen), 64'd1);
        @(posedge ACLK);
        #3 ARESETn = 0;
        mem_req = 0;
        #1;
        chk("rst_async_wvalid", 64'(WVALID), 64'd0);
        chk("rst_async_other", 64'({AWVALID, BREADY, ARVALID, RREADY, WLAST}), 64'd0);
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1;
        w_wait = 0;
        @(negedge ACLK);
        chk_reset_outputs("post_rst");
        @(posedge ACLK);
        #1;
        do_req(4'hF, 32'h0000_0044, 32'h0, lat, err, rd);
        chk("post_rst_rd_latency", 64'(lat), 64'd3);

        // randomized traffic against the model
        fix_en = 0;
        set_slave(0, 0, 60, 60);
        idle(1);
        for (int n = 0; n < 150; n++) begin
            if (chance(40)) begin
                web = 4'hF;
            end else begin
                do web = 4'($urandom); while (web == 4'hF);
            end
            do_req(web, $urandom, $urandom, lat, err, rd);
            if (chance(50)) idle($urandom_range(0, 3));
        end
        idle(3);
        chk("done_count", 64'(done_cnt), 64'(req_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
